// File: rtl/sort_frame_pkg.sv
// Shared types and helpers for the sort frame controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sort_frame_pkg;

    localparam int N_DEF     = 6;
    localparam int WIDTH_DEF = 8;

    typedef logic [WIDTH_DEF-1:0] word_t;

    // Controller states; kept as plain constants so legacy tools read them unchanged.
    typedef logic [1:0] state_t;
    localparam state_t S_LOAD  = 2'd0;
    localparam state_t S_SORT  = 2'd1;
    localparam state_t S_DRAIN = 2'd2;

    typedef struct packed {
        word_t hi;
        word_t lo;
    } pair_t;

    // Ordered pair: smaller word in lo, equal words keep their original order.
    function automatic pair_t cmp_swap(input word_t a, input word_t b);
        pair_t p;
        if (a > b) begin
            p.lo = b;
            p.hi = a;
        end else begin
            p.lo = a;
            p.hi = b;
        end
        return p;
    endfunction

endpackage

// File: rtl/sort_frame_controller_oet_pass.sv
// One odd-even transposition pass over a packed word bank.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module sort_frame_controller_oet_pass #(
    parameter int N     = 6,
    parameter int WIDTH = 8
) (
    input  logic [N*WIDTH-1:0] bank_i,
    input  logic               odd_i,
    output logic [N*WIDTH-1:0] bank_o
);

    // Compare-exchange each disjoint pair selected by the pass parity; pairs never overlap,
    // so every comparison reads the untouched input bank.
    always_comb begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bank_o = bank_i;
        a      = '0;
        b      = '0;
        for (int k = 0; k < N - 1; k++) begin
            if ((k % 2) == (odd_i ? 1 : 0)) begin
                a = bank_i[k*WIDTH +: WIDTH];
                b = bank_i[(k+1)*WIDTH +: WIDTH];
                if (a > b) begin
                    bank_o[k*WIDTH +: WIDTH]     = b;
                    bank_o[(k+1)*WIDTH +: WIDTH] = a;
                end
            end
        end
    end

endmodule

// File: rtl/sort_frame_controller.sv
// Loads up to N words, sorts them ascending with N odd-even passes, then drains them in order.
// Latency: N sort cycles after the last accepted word; first sorted word in the following cycle.
// Backpressure: in_ready only in LOAD; drain holds out_data/out_last stable while out_ready is low.
module sort_frame_controller
    import sort_frame_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_last,
    output logic [$clog2(N+1)-1:0]   frame_len,
    output logic                     busy
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q,    rd_cnt_d;
    logic [CNT_W-1:0]   pass_q,      pass_d;
    logic [CNT_W-1:0]   frame_len_q, frame_len_d;
    logic [N*WIDTH-1:0] bank_q,      bank_d;
    logic [N*WIDTH-1:0] pass_bank;

    sort_frame_controller_oet_pass #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_oet_pass (
        .bank_i (bank_q),
        .odd_i  (pass_q[0]),
        .bank_o (pass_bank)
    );

    // Output decode from registered state; abort blocks both handshakes in the same cycle.
    always_comb begin
        in_ready  = (state_q == S_LOAD) && !abort;
        out_valid = (state_q == S_DRAIN) && !abort;
        out_last  = (state_q == S_DRAIN) && (rd_cnt_q == frame_len_q - 1'b1);
        busy      = (state_q != S_LOAD) || (wr_cnt_q != '0);
        frame_len = frame_len_q;
        out_data  = '0;
        if (state_q == S_DRAIN) begin
            for (int i = 0; i < N; i++) begin
                if (rd_cnt_q == CNT_W'(i)) begin
                    out_data = bank_q[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next-state logic: fill, sort passes, drain, and abort recovery.
    always_comb begin
        state_d     = state_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        pass_d      = pass_q;
        frame_len_d = frame_len_q;
        bank_d      = bank_q;
        if (abort) begin
            state_d     = S_LOAD;
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            pass_d      = '0;
            frame_len_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        wr_cnt_d = wr_cnt_q + 1'b1;
                        for (int i = 0; i < N; i++) begin
                            if (CNT_W'(i) == wr_cnt_q) begin
                                bank_d[i*WIDTH +: WIDTH] = in_data;
                            end
                        end
                        if (in_last || (wr_cnt_q == LAST_IDX)) begin
                            frame_len_d = wr_cnt_q + 1'b1;
                            state_d     = S_SORT;
                            pass_d      = '0;
                            // Unused tail slots get the largest value so they sort behind real words.
                            for (int i = 0; i < N; i++) begin
                                if (CNT_W'(i) > wr_cnt_q) begin
                                    bank_d[i*WIDTH +: WIDTH] = '1;
                                end
                            end
                        end
                    end
                end
                S_SORT: begin
                    bank_d = pass_bank;
                    if (pass_q == LAST_IDX) begin
                        state_d  = S_DRAIN;
                        rd_cnt_d = '0;
                    end else begin
                        pass_d = pass_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (rd_cnt_q == frame_len_q - 1'b1) begin
                            state_d  = S_LOAD;
                            wr_cnt_d = '0;
                            rd_cnt_d = '0;
                        end else begin
                            rd_cnt_d = rd_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = S_LOAD;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    pass_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pass_q      <= '0;
            frame_len_q <= '0;
            bank_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pass_q      <= pass_d;
            frame_len_q <= frame_len_d;
            bank_q      <= bank_d;
        end
    end

endmodule

// File: tb/tb_sort_frame_controller.sv
// Directed bench for sort_frame_controller: table of frames plus abort and reset sequences.
// Latency: checks exact SORT length of N cycles before the first sorted word.
// Backpressure: one table entry drives an out_ready stall pattern and checks hold stability.
module tb_sort_frame_controller;

    localparam int N = 6;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         abort = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [2:0]   frame_len;
    logic         busy;

    int tests = 0;
    int fails = 0;

    sort_frame_controller #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_len (frame_len),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          len;
        logic [47:0] din;
        logic [47:0] exp;
        bit          mark_last;
        bit          bp;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [47:0] w6(input logic [7:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Present len words, one per cycle, driven at negedge.
    task automatic load_frame(input int len, input logic [47:0] din, input bit mark_last);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0) check("load_in_ready", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = din[i*8 +: 8];
            in_last  = mark_last && (i == len - 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            in_data  = '0;
        end
    endtask

    // Count SORT cycles (out_valid low) until the first sorted word; ends on a negedge.
    task automatic sort_wait(input int len);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            if (in_ready) bad++;
            n++;
            @(negedge clk);
        end
        check("sort_cycles", 32'(n), 32'(N));
        check("sort_in_ready_low", 32'(bad), 32'd0);
        check("frame_len", 32'(frame_len), 32'(len));
    endtask

    // Drain len words, optionally with a 1,0,0,1,0,1 out_ready pattern; starts/ends on a negedge.
    task automatic drain(input int len, input logic [47:0] exp, input bit bp);
        int k = 0;
        int cyc = 0;
        bit rdy;
        bit stalled = 1'b0;
        logic [7:0] sd = '0;
        logic sl = 1'b0;
        while (k < len && cyc < 200) begin
            rdy = bp ? ((cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5)) : 1'b1;
            out_ready = rdy;
            if (out_valid) begin
                if (stalled) begin
                    check("hold_data", 32'(out_data), 32'(sd));
                    check("hold_last", 32'(out_last), 32'(sl));
                end
                if (rdy) begin
                    check("out_data", 32'(out_data), 32'(exp[k*8 +: 8]));
                    check("out_last", 32'(out_last), 32'(k == len - 1));
                    k++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    sd = out_data;
                    sl = out_last;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_count", 32'(k), 32'(len));
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_frame(input int len, input logic [47:0] din, input logic [47:0] exp,
                             input bit mark_last, input bit bp);
        load_frame(len, din, mark_last);
        sort_wait(len);
        drain(len, exp, bp);
    endtask

    initial begin
        vecs[0] = '{"n6_last",  6, w6(5, 3, 9, 1, 7, 2),       w6(1, 2, 3, 5, 7, 9),       1'b1, 1'b0};
        vecs[1] = '{"short3",   3, w6(200, 0, 255, 0, 0, 0),   w6(0, 200, 255, 0, 0, 0),   1'b1, 1'b0};
        vecs[2] = '{"dups",     6, w6(4, 4, 1, 4, 1, 4),       w6(1, 1, 4, 4, 4, 4),       1'b0, 1'b0};
        vecs[3] = '{"max2",     2, w6(255, 255, 0, 0, 0, 0),   w6(255, 255, 0, 0, 0, 0),   1'b1, 1'b0};
        vecs[4] = '{"backpr",   6, w6(10, 50, 20, 40, 30, 60), w6(10, 20, 30, 40, 50, 60), 1'b0, 1'b1};

        // Reset values before any clock edge.
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].len, vecs[v].din, vecs[v].exp, vecs[v].mark_last, vecs[v].bp);
        end

        // Abort after two drain handshakes.
        load_frame(3, w6(30, 10, 20, 0, 0, 0), 1'b1);
        sort_wait(3);
        out_ready = 1'b1;
        check("ab_d0", 32'(out_data), 32'd10);
        @(posedge clk);
        @(negedge clk);
        check("ab_d1", 32'(out_data), 32'd20);
        @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        #1;
        check("ab_out_valid_same", 32'(out_valid), 32'd0);
        check("ab_in_ready_same", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("ab_in_ready_next", 32'(in_ready), 32'd1);
        check("ab_busy_next", 32'(busy), 32'd0);
        check("ab_frame_len", 32'(frame_len), 32'd0);
        check("ab_out_valid_next", 32'(out_valid), 32'd0);
        run_frame(2, w6(8, 6, 0, 0, 0, 0), w6(6, 8, 0, 0, 0, 0), 1'b1, 1'b0);

        // Asynchronous reset in the middle of SORT.
        load_frame(3, w6(3, 2, 1, 0, 0, 0), 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("mid_sort_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd1);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_data", 32'(out_data), 32'd0);
        check("ar_out_last", 32'(out_last), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_frame_len", 32'(frame_len), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(1, w6(8'h7F, 0, 0, 0, 0, 0), w6(8'h7F, 0, 0, 0, 0, 0), 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
